// File: rtl/mase_fixed_pkg.sv
// Shared fixed-point helpers for the streaming dot-product blocks:
// result/accumulator width rules and the accumulate/present state encoding.
package mase_fixed_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Full-precision width of a sum of parallelism*depth products, so no beat can overflow.
  function automatic int acc_width(input int data_w, input int weight_w,
                                   input int parallelism, input int depth);
    return data_w + weight_w + $clog2(parallelism * depth);
  endfunction

  function automatic int count_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fixed_dot_product_lanes.sv
// Combinational lane multipliers plus reduction: signed full-precision sum of
// PARALLELISM activation*weight products, sign-extended to OUT_W.
module fixed_dot_product_lanes #(
  parameter int DATA_IN_PRECISION_0 = 16,
  parameter int WEIGHT_PRECISION_0  = 16,
  parameter int PARALLELISM         = 4,
  parameter int OUT_W               = 37
) (
  input  logic        [PARALLELISM-1:0][DATA_IN_PRECISION_0-1:0] data_in,
  input  logic        [PARALLELISM-1:0][WEIGHT_PRECISION_0-1:0]  weight,
  output logic signed [OUT_W-1:0]                                beat_sum
);

  localparam int PROD_W = DATA_IN_PRECISION_0 + WEIGHT_PRECISION_0;

  logic signed [PROD_W-1:0] prod [PARALLELISM];

  always_comb begin
    for (int i = 0; i < PARALLELISM; i++) begin
      prod[i] = $signed(data_in[i]) * $signed(weight[i]);
    end
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      beat_sum = beat_sum + OUT_W'(prod[i]);
    end
  end

endmodule

// File: rtl/weight_stream_dot_acc.sv
// Joins an activation stream and a weight stream beat-by-beat, accumulates
// IN_DEPTH lane dot products and presents the sum on a valid/ready output.
module weight_stream_dot_acc
  import mase_fixed_pkg::*;
#(
  parameter int DATA_IN_PRECISION_0 = 16,
  parameter int DATA_IN_PRECISION_1 = 3,
  parameter int WEIGHT_PRECISION_0  = 16,
  parameter int WEIGHT_PRECISION_1  = 3,
  parameter int PARALLELISM         = 4,
  parameter int IN_DEPTH            = 8,
  localparam int DATA_OUT_PRECISION_0 =
    acc_width(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0, PARALLELISM, IN_DEPTH),
  localparam int DATA_OUT_PRECISION_1 = DATA_IN_PRECISION_1 + WEIGHT_PRECISION_1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic        [PARALLELISM-1:0][DATA_IN_PRECISION_0-1:0] data_in,
  input  logic                                                  data_in_valid,
  output logic                                                  data_in_ready,
  input  logic        [PARALLELISM-1:0][WEIGHT_PRECISION_0-1:0]  weight,
  input  logic                                                  weight_valid,
  output logic                                                  weight_ready,
  output logic signed [DATA_OUT_PRECISION_0-1:0]                data_out,
  output logic                                                  data_out_valid,
  input  logic                                                  data_out_ready
);

  localparam int CNT_W = count_width(IN_DEPTH);

  if (IN_DEPTH < 1) begin : g_bad_depth
    $error("IN_DEPTH must be at least 1");
  end
  if (DATA_OUT_PRECISION_1 >= DATA_OUT_PRECISION_0) begin : g_bad_frac
    $error("fractional bits exceed result width");
  end

  state_t                           state;
  logic   [CNT_W-1:0]               count;
  logic signed [DATA_OUT_PRECISION_0-1:0] acc;
  logic signed [DATA_OUT_PRECISION_0-1:0] beat_sum_p0;
  logic                             vld_p0;
  logic                             last_beat;

  // Stage p0: combinational lane products for the beat offered this cycle.
  fixed_dot_product_lanes #(
    .DATA_IN_PRECISION_0 (DATA_IN_PRECISION_0),
    .WEIGHT_PRECISION_0  (WEIGHT_PRECISION_0),
    .PARALLELISM         (PARALLELISM),
    .OUT_W               (DATA_OUT_PRECISION_0)
  ) u_lanes (
    .data_in  (data_in),
    .weight   (weight),
    .beat_sum (beat_sum_p0)
  );

  // Each ready depends only on the other stream's valid, so a beat is taken
  // from both streams together or from neither.
  assign data_in_ready = !rst && (state == ACCUM) && weight_valid;
  assign weight_ready  = !rst && (state == ACCUM) && data_in_valid;
  assign vld_p0        = !rst && (state == ACCUM) && data_in_valid && weight_valid;
  assign last_beat     = (count == CNT_W'(IN_DEPTH - 1));

  // Stage p1: accumulator, beat counter and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACCUM;
      count          <= '0;
      acc            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (vld_p0) begin
            if (last_beat) begin
              data_out       <= acc + beat_sum_p0;
              data_out_valid <= 1'b1;
              count          <= '0;
              state          <= HOLD;
            end else begin
              acc   <= acc + beat_sum_p0;
              count <= count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (data_out_ready) begin
            acc            <= '0;
            data_out_valid <= 1'b0;
            state          <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/weight_stream_dot_acc.md
WEIGHT_STREAM_DOT_ACC -- requirements
Module: weight_stream_dot_acc

Interface
REQ-001 SHALL have parameter DATA_IN_PRECISION_0, default 16, activation total bits (signed fixed-point).
REQ-002 SHALL have parameter DATA_IN_PRECISION_1, default 3, activation fractional bits.
REQ-003 SHALL have parameter WEIGHT_PRECISION_0, default 16, weight total bits (signed fixed-point).
REQ-004 SHALL have parameter WEIGHT_PRECISION_1, default 3, weight fractional bits.
REQ-005 SHALL have parameter PARALLELISM, default 4, lanes per beat on both input streams.
REQ-006 SHALL have parameter IN_DEPTH, default 8, beats summed per output (≥1).
REQ-007 SHALL derive DATA_OUT_PRECISION_0 = DATA_IN_PRECISION_0 + WEIGHT_PRECISION_0 + $clog2(PARALLELISM*IN_DEPTH) and DATA_OUT_PRECISION_1 = DATA_IN_PRECISION_1 + WEIGHT_PRECISION_1.
REQ-008 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-009 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-010 SHALL have port data_in  input  [DATA_IN_PRECISION_0-1:0] x PARALLELISM  activation lanes.
REQ-011 SHALL have ports data_in_valid input 1 and data_in_ready output 1  activation handshake.
REQ-012 SHALL have port weight  input  [WEIGHT_PRECISION_0-1:0] x PARALLELISM  weight lanes from the parameter source stage.
REQ-013 SHALL have ports weight_valid input 1 and weight_ready output 1  weight handshake.
REQ-014 SHALL have port data_out  output  [DATA_OUT_PRECISION_0-1:0]  signed dot-product result.
REQ-015 SHALL have ports data_out_valid output 1 and data_out_ready input 1  result handshake.

Function
REQ-016 SHALL implement two states: ACCUM (accepting beats) and HOLD (presenting result).
REQ-017 SHALL assert data_in_ready = (state==ACCUM) && weight_valid and weight_ready = (state==ACCUM) && data_in_valid; a beat fires only when both streams transfer in the same cycle.
REQ-018 SHALL never consume one stream without the other; weight_ready never depends on weight_valid, data_in_ready never on data_in_valid.
REQ-019 SHALL compute per fired beat the full-precision signed sum of PARALLELISM lane products, sign-extended to DATA_OUT_PRECISION_0, and add it to the accumulator; no rounding, no saturation (width guarantees no overflow).
REQ-020 SHALL count fired beats 0..IN_DEPTH-1; on the beat with count==IN_DEPTH-1, register acc+beat_sum into data_out, reset count to 0, go to HOLD.
REQ-021 SHALL assert data_out_valid only in HOLD; data_out stable while data_out_valid && !data_out_ready.
REQ-022 SHALL in HOLD with data_out_ready=1 return to ACCUM next cycle with accumulator cleared; no beat fires in HOLD (one bubble cycle per output).
REQ-023 SHALL give latency of exactly 1 cycle from last beat fired to data_out_valid high.
REQ-024 SHALL for IN_DEPTH==1 enter HOLD after every fired beat.
REQ-025 SHALL hold count and accumulator unchanged on cycles where no beat fires (either valid low).

Reset
REQ-026 SHALL on rst=1 at a clock edge set state=ACCUM, count=0, accumulator=0, data_out=0, data_out_valid=0, discarding any partial sum or held result.
REQ-027 SHALL drive data_in_ready=0 and weight_ready=0 during cycles with rst=1.

Structure
REQ-028 SHALL place the output-width computation (accumulator width function) and the state enum in shared package mase_fixed_pkg.
REQ-029 SHALL instantiate one combinational sub-module, fixed_dot_product_lanes (PARALLELISM multipliers + adder tree), with FSM, counter and accumulator in the top.

Verification
REQ-030 SHALL test defaults, all lanes data_in=8 (1.0), weight=8 (1.0), valids held high 8 cycles -> one output data_out=2048 (32.0 at 6 frac bits), valid exactly 1 cycle after 8th beat.
REQ-031 SHALL test signs: data_in=-8, weight=16 all lanes, 8 beats -> data_out=-4096.
REQ-032 SHALL test stalls: toggle data_in_valid randomly with weight_valid=1 -> identical result to REQ-030, beat count unaffected by stalled cycles, weight_ready low whenever data_in_valid low.
REQ-033 SHALL test backpressure: data_out_ready=0 for 5 cycles in HOLD -> data_out stable, both input readys low, next output sequence starts only after acceptance.
REQ-034 SHALL test extremes: data_in=-32768, weight=-32768 all lanes, 8 beats -> data_out=2^30*32=34359738368, no overflow.
REQ-035 SHALL test reset mid-accumulation: rst after 5 beats, then 8 fresh beats of REQ-030 -> data_out=2048.
